// File: rtl/start_seq_if.sv
// Handshake bundle between the request source/datapath side and the start sequencer.
interface start_seq_if #(
  parameter int CNT_W = 8
);
  logic             req_i;
  logic             done_i;
  logic             abort_i;
  logic             busy_o;
  logic             start_o;
  logic             timeout_o;
  logic [CNT_W-1:0] start_count_o;

  modport master (
    output req_i, done_i, abort_i,
    input  busy_o, start_o, timeout_o, start_count_o
  );

  modport slave (
    input  req_i, done_i, abort_i,
    output busy_o, start_o, timeout_o, start_count_o
  );
endinterface

// File: rtl/start_seq_ctrl.sv
// Start sequencer: turns a request rising edge into a delayed one-cycle start
// pulse, then waits for done with a timeout. busy_o covers the whole sequence.
//
// state  | meaning
// IDLE   | waiting for a request rising edge
// ARM    | delay counter running toward the start pulse
// FIRE   | start_o asserted for one cycle, start count bumped
// WAIT   | waiting for done_i, bounded by the wait counter
module start_seq_ctrl #(
  parameter int START_DELAY = 3,
  parameter int TIMEOUT     = 20,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  start_seq_if.slave  bus
);

  localparam int DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_FIRE = 2'd2,
    S_WAIT = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic [TMO_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d;
  logic               req_q;
  logic               rise;

  // req_q resets high so a request already asserted at reset release is not an edge
  assign rise = bus.req_i & ~req_q;

  // State, counters and registered outputs with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      dly_q     <= '0;
      wait_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      req_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      wait_q    <= wait_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      req_q     <= bus.req_i;
    end
  end

  // Next-state logic; abort beats done beats timeout in WAIT, abort ignored in FIRE
  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    wait_d    = wait_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_ARM;
          dly_d   = DLY_W'(START_DELAY - 1);
        end
      end
      S_ARM: begin
        if (bus.abort_i) begin
          state_d = S_IDLE;
        end else if (dly_q == '0) begin
          state_d = S_FIRE;
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
      S_FIRE: begin
        state_d = S_WAIT;
        wait_d  = TMO_W'(TIMEOUT - 1);
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (bus.abort_i) begin
          state_d = S_IDLE;
        end else if (bus.done_i) begin
          state_d = S_IDLE;
        end else if (wait_q == '0) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy_o        = (state_q != S_IDLE);
  assign bus.start_o       = (state_q == S_FIRE);
  assign bus.timeout_o     = timeout_q;
  assign bus.start_count_o = cnt_q;

endmodule
